// File: rtl/rect_fill_engine_pkg.sv
// Shared defaults for the paint path: screen geometry and fill FSM encodings.
// Imported by rect_clip and rect_fill_engine; the display controller uses the same defaults.
package rect_fill_engine_pkg;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;
  localparam int unsigned CW_DEF    = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/rect_fill_engine_clip.sv
// rect_clip: orders rectangle corners and clamps them to the screen.
// Ports: x0,x1,y0,y1 corners in; xl,xr,yt,yb clipped box and empty flag out.
module rect_clip
  import rect_fill_engine_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] y1,
  output logic [CW-1:0] xl,
  output logic [CW-1:0] xr,
  output logic [CW-1:0] yt,
  output logic [CW-1:0] yb,
  output logic          empty
);

  localparam logic [CW-1:0] XMAX = CW'(H_RES - 1);
  localparam logic [CW-1:0] YMAX = CW'(V_RES - 1);

  logic [CW-1:0] xhi;
  logic [CW-1:0] yhi;

  always_comb begin
    xl  = (x0 < x1) ? x0 : x1;
    xhi = (x0 < x1) ? x1 : x0;
    yt  = (y0 < y1) ? y0 : y1;
    yhi = (y0 < y1) ? y1 : y0;
    xr  = (xhi > XMAX) ? XMAX : xhi;
    yb  = (yhi > YMAX) ? YMAX : yhi;
    // box lies wholly off-screen when its near edge is past the limit
    empty = (32'(xl) >= H_RES) || (32'(yt) >= V_RES);
  end

endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: clips one rectangle command and streams index-RAM writes row-major.
// Ports: iCLK/iRST_n, iCMD_VALID/oCMD_READY, iX0..iY1, iCOLOR, iABORT, oADDR/oDATA/oWREN, oBUSY, oDONE.
module rect_fill_engine
  import rect_fill_engine_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  input  logic          iCMD_VALID,
  output logic          oCMD_READY,
  input  logic [CW-1:0] iX0,
  input  logic [CW-1:0] iX1,
  input  logic [CW-1:0] iY0,
  input  logic [CW-1:0] iY1,
  input  logic [7:0]    iCOLOR,
  input  logic          iABORT,
  output logic [31:0]   oADDR,
  output logic [31:0]   oDATA,
  output logic          oWREN,
  output logic          oBUSY,
  output logic          oDONE
);

  logic [1:0]    state;
  logic [CW-1:0] cx0, cx1, cy0, cy1;
  logic [7:0]    color;
  logic [CW-1:0] xl, xr, yb;
  logic [CW-1:0] x, y;
  logic [31:0]   row_base;

  logic [CW-1:0] c_xl, c_xr, c_yt, c_yb;
  logic          c_empty;

  rect_clip #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .CW   (CW)
  ) u_clip (
    .x0   (cx0),
    .x1   (cx1),
    .y0   (cy0),
    .y1   (cy1),
    .xl   (c_xl),
    .xr   (c_xr),
    .yt   (c_yt),
    .yb   (c_yb),
    .empty(c_empty)
  );

  assign oCMD_READY = (state == ST_IDLE);
  assign oBUSY      = (state != ST_IDLE);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= ST_IDLE;
      cx0      <= '0;
      cx1      <= '0;
      cy0      <= '0;
      cy1      <= '0;
      color    <= '0;
      xl       <= '0;
      xr       <= '0;
      yb       <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
      oADDR    <= '0;
      oDATA    <= '0;
      oWREN    <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      oWREN <= 1'b0;
      oDONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (iCMD_VALID) begin
            cx0   <= iX0;
            cx1   <= iX1;
            cy0   <= iY0;
            cy1   <= iY1;
            color <= iCOLOR;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (iABORT || c_empty) begin
            state <= ST_DONE;
          end else begin
            xl       <= c_xl;
            xr       <= c_xr;
            yb       <= c_yb;
            x        <= c_xl;
            y        <= c_yt;
            // only multiply in the datapath; rows advance by addition
            row_base <= 32'(c_yt) * 32'(H_RES);
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (iABORT) begin
            state <= ST_DONE;
          end else begin
            oWREN <= 1'b1;
            oADDR <= row_base + 32'(x);
            oDATA <= {24'd0, color};
            if (x < xr) begin
              x <= x + CW'(1);
            end else if (y < yb) begin
              x        <= xl;
              y        <= y + CW'(1);
              row_base <= row_base + 32'(H_RES);
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          oDONE <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine.
// Samples 1 time unit after each rising edge; cycle numbers count edges after acceptance.
module tb_rect_fill_engine;

  logic        iCLK;
  logic        iRST_n;
  logic        iCMD_VALID;
  logic        oCMD_READY;
  logic [9:0]  iX0, iX1, iY0, iY1;
  logic [7:0]  iCOLOR;
  logic        iABORT;
  logic [31:0] oADDR;
  logic [31:0] oDATA;
  logic        oWREN;
  logic        oBUSY;
  logic        oDONE;

  int checks = 0;
  int errors = 0;

  int q[$];
  int cyc, first_cyc, last_cyc, done_cyc, data_bad;
  logic busy0, rdy0;
  int stray;

  rect_fill_engine dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iCMD_VALID(iCMD_VALID),
    .oCMD_READY(oCMD_READY),
    .iX0       (iX0),
    .iX1       (iX1),
    .iY0       (iY0),
    .iY1       (iY1),
    .iCOLOR    (iCOLOR),
    .iABORT    (iABORT),
    .oADDR     (oADDR),
    .oDATA     (oDATA),
    .oWREN     (oWREN),
    .oBUSY     (oBUSY),
    .oDONE     (oDONE)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic send(input int x0, input int y0,
                      input int x1, input int y1,
                      input int col);
    int w;
    w = 0;
    while (!oCMD_READY && w < 5000) begin
      @(posedge iCLK);
      #1;
      w++;
    end
    iX0 = 10'(x0);
    iY0 = 10'(y0);
    iX1 = 10'(x1);
    iY1 = 10'(y1);
    iCOLOR = 8'(col);
    iCMD_VALID = 1'b1;
    @(posedge iCLK);
    #1;
    iCMD_VALID = 1'b0;
    busy0 = oBUSY;
    rdy0 = oCMD_READY;
  endtask

  task automatic collect(input int budget, input int abort_after,
                         input int col);
    q.delete();
    cyc = 0;
    first_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
    data_bad = 0;
    while (done_cyc < 0 && cyc < budget) begin
      @(posedge iCLK);
      #1;
      cyc++;
      if (oWREN) begin
        q.push_back(int'(oADDR));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (oDATA !== 32'(col)) data_bad++;
        if (abort_after > 0 && q.size() == abort_after) iABORT = 1'b1;
      end
      if (oDONE) done_cyc = cyc;
    end
    iABORT = 1'b0;
  endtask

  initial begin
    int exp1[6];
    exp1 = '{12810, 12811, 12812, 13450, 13451, 13452};
    iRST_n = 1'b0;
    iCMD_VALID = 1'b0;
    iX0 = '0;
    iX1 = '0;
    iY0 = '0;
    iY1 = '0;
    iCOLOR = '0;
    iABORT = 1'b0;

    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_ready", oCMD_READY, 1);
    chk("rst_wren", oWREN, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_done", oDONE, 0);
    chk("rst_addr", oADDR, 0);
    chk("rst_data", oDATA, 0);
    iRST_n = 1'b1;
    @(posedge iCLK);
    #1;

    // 1: small box
    send(10, 20, 12, 21, 8'h3C);
    chk("t1_busy0", busy0, 1);
    chk("t1_ready0", rdy0, 0);
    collect(100, 0, 8'h3C);
    chk("t1_count", q.size(), 6);
    for (int i = 0; i < 6; i++) chk("t1_addr", qget(i), exp1[i]);
    chk("t1_data", data_bad, 0);
    chk("t1_first_cyc", first_cyc, 2);
    chk("t1_last_cyc", last_cyc, 7);
    chk("t1_done_cyc", done_cyc, 8);
    @(posedge iCLK);
    #1;
    chk("t1_done_1cyc", oDONE, 0);
    chk("t1_ready_back", oCMD_READY, 1);

    // 2: reversed corners
    send(12, 21, 10, 20, 8'h3C);
    collect(100, 0, 8'h3C);
    chk("t2_count", q.size(), 6);
    for (int i = 0; i < 6; i++) chk("t2_addr", qget(i), exp1[i]);
    chk("t2_done_cyc", done_cyc, 8);

    // 3: clipped at bottom-right
    send(630, 470, 1000, 900, 8'hA5);
    collect(300, 0, 8'hA5);
    chk("t3_count", q.size(), 100);
    chk("t3_first", qget(0), 301430);
    chk("t3_row2", qget(10), 302070);
    chk("t3_last", qget(99), 307199);
    chk("t3_data", data_bad, 0);
    chk("t3_done_cyc", done_cyc, 102);

    // 4: entirely off-screen
    send(700, 5, 800, 9, 8'h11);
    collect(20, 0, 8'h11);
    chk("t4_count", q.size(), 0);
    chk("t4_done_cyc", done_cyc, 2);
    @(posedge iCLK);
    #1;
    chk("t4_ready", oCMD_READY, 1);

    // 5: full screen aborted after 1000 writes, then a normal command
    send(0, 0, 639, 479, 8'h55);
    collect(3000, 1000, 8'h55);
    chk("t5_count", q.size(), 1000);
    chk("t5_last", qget(999), 999);
    chk("t5_last_cyc", last_cyc, 1001);
    chk("t5_done_cyc", done_cyc, 1003);
    send(5, 1, 6, 1, 8'h07);
    collect(50, 0, 8'h07);
    chk("t5b_count", q.size(), 2);
    chk("t5b_a0", qget(0), 645);
    chk("t5b_a1", qget(1), 646);
    chk("t5b_done_cyc", done_cyc, 4);

    // 6: asynchronous reset mid-fill
    send(0, 0, 639, 479, 8'h66);
    repeat (50) @(posedge iCLK);
    #3;
    chk("t6_pre_wren", oWREN, 1);
    iRST_n = 1'b0;
    #1;
    chk("t6_wren", oWREN, 0);
    chk("t6_busy", oBUSY, 0);
    chk("t6_done", oDONE, 0);
    chk("t6_addr", oADDR, 0);
    stray = 0;
    repeat (3) begin
      @(posedge iCLK);
      #1;
      if (oWREN || oDONE) stray++;
    end
    iRST_n = 1'b1;
    repeat (3) begin
      @(posedge iCLK);
      #1;
      if (oWREN || oDONE) stray++;
    end
    chk("t6_stray", stray, 0);
    chk("t6_ready", oCMD_READY, 1);
    send(0, 0, 0, 0, 8'h9A);
    collect(50, 0, 8'h9A);
    chk("t6_px_count", q.size(), 1);
    chk("t6_px_addr", qget(0), 0);
    chk("t6_px_data", data_bad, 0);
    chk("t6_px_done", done_cyc, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
